// File: rtl/controlador_interrupciones_pkg.sv
// Shared constants for the interrupt controller: E/S register offsets,
// FSM state encoding, interrupt code width and the ESTADO register packing.
package controlador_interrupciones_pkg;

   localparam int ANCHO_CODIGO = 3;
   localparam logic [ANCHO_CODIGO-1:0] CODIGO_NINGUNA = 3'b000;

   // Register offsets inside the 4-register E/S window
   localparam logic [1:0] OFF_MASCARA    = 2'd0;
   localparam logic [1:0] OFF_PENDIENTES = 2'd1;
   localparam logic [1:0] OFF_ESTADO     = 2'd2;
   localparam logic [1:0] OFF_FIN        = 2'd3;

   // FSM state encoding
   localparam logic [1:0] REPOSO      = 2'd0;
   localparam logic [1:0] PRESENTANDO = 2'd1;
   localparam logic [1:0] SERVICIO    = 2'd2;

   // ESTADO layout: [7] presentando, [6] en_servicio, [2:0] code being handled
   function automatic logic [7:0] empaquetar_estado(input logic [1:0]              estado,
                                                    input logic [ANCHO_CODIGO-1:0] codigo);
      return {(estado == PRESENTANDO), (estado == SERVICIO), 3'b000, codigo};
   endfunction

endpackage

// File: rtl/controlador_interrupciones_prioridad.sv
// Fixed-priority encoder: bit 0 is the most urgent request. Produces the
// interrupt code (index + 1) and a valid flag; code 000 means "none".
module codificador_prioridad
   import controlador_interrupciones_pkg::*;
(
   input  logic [6:0]              i_solicitudes,
   output logic [ANCHO_CODIGO-1:0] o_codigo,
   output logic                    o_valido
);

   // Scan from the least urgent line down so the lowest index wins
   always_comb begin
      o_codigo = CODIGO_NINGUNA;
      o_valido = 1'b0;
      for (int k = 6; k >= 0; k--) begin
         if (i_solicitudes[k]) begin
            o_codigo = ANCHO_CODIGO'(k + 1);
            o_valido = 1'b1;
         end
      end
   end

endmodule

// File: rtl/controlador_interrupciones.sv
// Interrupt controller on the requesting side of the CPU interrupt interface.
// Synchronises seven request lines, keeps mask/pending registers behind a
// small E/S window and presents one code at a time to the datapath.
//
// Handshake: a nonzero `interrupciones` is the request (valid). It stays
// stable until the control unit pulses `ack` for one cycle (ready); the
// accepted source is then in service and no other code is offered until the
// service routine writes the FIN register (end-of-interrupt).
module controlador_interrupciones
   import controlador_interrupciones_pkg::*;
#(
   parameter int         N_FUENTES = 7,
   parameter logic [6:0] DIR_BASE  = 7'h00
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_FUENTES-1:0]    irq,
   input  logic                    ack,
   input  logic                    es_activar,
   input  logic                    es_escribir,
   input  logic [6:0]              es_direccion,
   input  logic [7:0]              es_dato_in,
   output logic [7:0]              es_dato_out,
   output logic [ANCHO_CODIGO-1:0] interrupciones
);

   logic [N_FUENTES-1:0]    r_sync1;
   logic [N_FUENTES-1:0]    r_sync2;
   logic [N_FUENTES-1:0]    r_sync3;
   logic [N_FUENTES-1:0]    r_pendientes;
   logic [7:0]              r_mascara;
   logic [1:0]              r_estado;
   logic [ANCHO_CODIGO-1:0] r_codigo;
   logic [ANCHO_CODIGO-1:0] r_interrupciones;

   logic                    w_en_ventana;
   logic [1:0]              w_offset;
   logic                    w_escritura;
   logic                    w_lectura;
   logic                    w_eoi;
   logic                    w_ack_valido;
   logic [N_FUENTES-1:0]    w_flancos;
   logic [N_FUENTES-1:0]    w_w1c;
   logic [N_FUENTES-1:0]    w_borrar_ack;
   logic [N_FUENTES-1:0]    w_solicitudes;
   logic [ANCHO_CODIGO-1:0] w_cand_codigo;
   logic                    w_cand_valido;
   logic [7:0]              w_estado_reg;

   // Address decode: the window is selected by the upper five address bits
   assign w_en_ventana = (es_direccion[6:2] == DIR_BASE[6:2]);
   assign w_offset     = es_direccion[1:0];
   assign w_escritura  = es_activar & es_escribir & w_en_ventana;
   assign w_lectura    = es_activar & ~es_escribir & w_en_ventana;
   assign w_eoi        = w_escritura & (w_offset == OFF_FIN);

   // Only the presented source may be acknowledged; stale acks are dropped
   assign w_ack_valido = ack & (r_estado == PRESENTANDO);
   assign w_borrar_ack = w_ack_valido ? (N_FUENTES'(1) << (r_codigo - 3'd1))
                                      : '0;

   // A request is a 0->1 transition seen after synchronisation
   assign w_flancos = r_sync2 & ~r_sync3;
   assign w_w1c     = (w_escritura && (w_offset == OFF_PENDIENTES))
                      ? es_dato_in[N_FUENTES-1:0] : '0;

   // Candidates need their own enable and the global enable (mask bit 7)
   assign w_solicitudes = r_pendientes & r_mascara[N_FUENTES-1:0]
                          & {N_FUENTES{r_mascara[7]}};

   codificador_prioridad u_prioridad (
      .i_solicitudes (w_solicitudes),
      .o_codigo      (w_cand_codigo),
      .o_valido      (w_cand_valido)
   );

   assign w_estado_reg   = empaquetar_estado(r_estado, r_codigo);
   assign interrupciones = r_interrupciones;

   // Two-flop synchroniser plus a third flop for rising-edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_sync3 <= '0;
      end else begin
         r_sync1 <= irq;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   // Pending bits: a new edge wins over both W1C and the ack clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pendientes <= '0;
      end else begin
         r_pendientes <= (r_pendientes & ~w_w1c & ~w_borrar_ack) | w_flancos;
      end
   end

   // Mask register, written through offset 0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mascara <= 8'h00;
      end else if (w_escritura && (w_offset == OFF_MASCARA)) begin
         r_mascara <= es_dato_in;
      end
   end

   // Presentation FSM with registered code output; no nesting of services
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_estado         <= REPOSO;
         r_codigo         <= CODIGO_NINGUNA;
         r_interrupciones <= CODIGO_NINGUNA;
      end else begin
         case (r_estado)
            REPOSO: begin
               if (w_cand_valido) begin
                  r_estado         <= PRESENTANDO;
                  r_codigo         <= w_cand_codigo;
                  r_interrupciones <= w_cand_codigo;
               end
            end
            PRESENTANDO: begin
               // Code is frozen here: new requests or mask edits do not move it
               if (ack) begin
                  r_estado         <= SERVICIO;
                  r_interrupciones <= CODIGO_NINGUNA;
               end
            end
            SERVICIO: begin
               if (w_eoi) begin
                  r_estado <= REPOSO;
                  r_codigo <= CODIGO_NINGUNA;
               end
            end
            default: begin
               r_estado         <= REPOSO;
               r_codigo         <= CODIGO_NINGUNA;
               r_interrupciones <= CODIGO_NINGUNA;
            end
         endcase
      end
   end

   // Combinational read mux; anything outside a valid read returns 00
   always_comb begin
      es_dato_out = 8'h00;
      if (w_lectura) begin
         case (w_offset)
            OFF_MASCARA:    es_dato_out = r_mascara;
            OFF_PENDIENTES: es_dato_out = {1'b0, r_pendientes};
            OFF_ESTADO:     es_dato_out = w_estado_reg;
            default:        es_dato_out = 8'h00;
         endcase
      end
   end

endmodule
